// File: rtl/cpu_host_port.sv
// Host-side driver for the CPU byte-load / readback port: one-byte writes held for
// HOLD_CYCLES, word reads assembled over vout_addr. Optional: CPU_HOST_POSCAP_EN.
module cpu_host_port #(
   parameter int HOLD_CYCLES = 4,
   parameter int SETTLE      = 2,
   parameter int NBYTES      = 4
) (
   input  logic        clk_i,
   input  logic        reset,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_op_i,
   input  logic        cmd_sel_i,
   input  logic [4:0]  cmd_addr_i,
   input  logic [7:0]  cmd_data_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
`ifdef CPU_HOST_POSCAP_EN
   input  logic        is_positive_i,
   output logic        rsp_pos_o,
`endif
   output logic        dor_o,
   output logic [4:0]  addr_o,
   output logic [7:0]  instr_o,
   output logic [1:0]  vout_addr_o,
   input  logic [7:0]  value_i
);

   localparam int CNT_MAX = (HOLD_CYCLES > SETTLE) ? HOLD_CYCLES : SETTLE;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
   localparam logic [1:0]    LAST_BYTE   = 2'(NBYTES - 1);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_HOLD = 2'd1,
      RD_WAIT = 2'd2,
      RSP     = 2'd3
   } state_e;

   state_e        state_q,    state_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [1:0]    k_q,        k_d;
   logic          dor_q,      dor_d;
   logic [4:0]    addr_q,     addr_d;
   logic [7:0]    instr_q,    instr_d;
   logic [1:0]    vout_q,     vout_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
`ifdef CPU_HOST_POSCAP_EN
   logic          pos_q,      pos_d;
`endif

   always_comb begin
      // NOTE: every signal gets its hold value first, so no path through the case
      // statement leaves one unassigned and no latch is inferred.
      state_d    = state_q;
      cnt_d      = cnt_q;
      k_d        = k_q;
      dor_d      = dor_q;
      addr_d     = addr_q;
      instr_d    = instr_q;
      vout_d     = vout_q;
      rsp_data_d = rsp_data_q;
`ifdef CPU_HOST_POSCAP_EN
      pos_d      = pos_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               if (cmd_op_i == OP_WRITE) begin
                  state_d = WR_HOLD;
                  dor_d   = cmd_sel_i;
                  addr_d  = cmd_addr_i;
                  instr_d = cmd_data_i;
                  cnt_d   = HOLD_LOAD;
               end else if (cmd_op_i == OP_READ) begin
                  state_d    = RD_WAIT;
                  dor_d      = cmd_sel_i;
                  addr_d     = cmd_addr_i;
                  vout_d     = 2'd0;
                  k_d        = 2'd0;
                  cnt_d      = SETTLE_LOAD;
                  rsp_data_d = 32'd0;
`ifdef CPU_HOST_POSCAP_EN
                  pos_d      = 1'b0;
`endif
               end
               // Reserved opcodes are consumed here with no visible effect.
            end
         end

         WR_HOLD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         RD_WAIT: begin
            if (cnt_q == '0) begin
               rsp_data_d[8*k_q +: 8] = value_i;
               if (k_q == LAST_BYTE) begin
                  state_d = RSP;
`ifdef CPU_HOST_POSCAP_EN
                  pos_d   = is_positive_i;
`endif
               end else begin
                  k_d    = k_q + 2'd1;
                  vout_d = k_q + 2'd1;
                  cnt_d  = SETTLE_LOAD;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         RSP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         k_q        <= 2'd0;
         dor_q      <= 1'b0;
         addr_q     <= 5'd0;
         instr_q    <= 8'd0;
         vout_q     <= 2'd0;
         rsp_data_q <= 32'd0;
`ifdef CPU_HOST_POSCAP_EN
         pos_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         k_q        <= k_d;
         dor_q      <= dor_d;
         addr_q     <= addr_d;
         instr_q    <= instr_d;
         vout_q     <= vout_d;
         rsp_data_q <= rsp_data_d;
`ifdef CPU_HOST_POSCAP_EN
         pos_q      <= pos_d;
`endif
      end
   end

   assign cmd_ready_o = (state_q == IDLE);
   assign rsp_valid_o = (state_q == RSP);
   assign rsp_data_o  = rsp_data_q;
   assign dor_o       = dor_q;
   assign addr_o      = addr_q;
   assign instr_o     = instr_q;
   assign vout_addr_o = vout_q;
`ifdef CPU_HOST_POSCAP_EN
   assign rsp_pos_o   = pos_q;
`endif

endmodule

// File: tb/tb_cpu_host_port.sv
// Directed bench for cpu_host_port: a command vector table plus hand sequences for
// backpressure, mid-read reset and an NBYTES=2 instance.
module tb_cpu_host_port;

   logic        clk_i = 1'b0;
   logic        reset = 1'b1;

   // Instance A: default parameters.
   logic        a_valid = 1'b0, a_ready, a_sel = 1'b0, a_rsp_valid, a_rsp_ready = 1'b0;
   logic [1:0]  a_op = 2'b00, a_vout;
   logic [4:0]  a_addr_i = 5'd0, a_addr;
   logic [7:0]  a_data_i = 8'd0, a_instr, a_value;
   logic [31:0] a_rsp_data, a_mem = 32'd0;
   logic        a_dor;

   // Instance B: NBYTES = 2.
   logic        b_valid = 1'b0, b_ready, b_sel = 1'b0, b_rsp_valid, b_rsp_ready = 1'b0;
   logic [1:0]  b_op = 2'b00, b_vout;
   logic [4:0]  b_addr_i = 5'd0, b_addr;
   logic [7:0]  b_data_i = 8'd0, b_instr, b_value;
   logic [31:0] b_rsp_data, b_mem = 32'd0;
   logic        b_dor;

`ifdef CPU_HOST_POSCAP_EN
   logic a_pos, b_pos, b_is_pos;
   assign b_is_pos = (b_vout == 2'd1);
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   // CPU readback model: value_o is the byte of the stored word selected by vout_addr.
   assign a_value = a_mem[8*a_vout +: 8];
   assign b_value = b_mem[8*b_vout +: 8];

   cpu_host_port u_a (
      .clk_i(clk_i), .reset(reset),
      .cmd_valid_i(a_valid), .cmd_ready_o(a_ready), .cmd_op_i(a_op),
      .cmd_sel_i(a_sel), .cmd_addr_i(a_addr_i), .cmd_data_i(a_data_i),
      .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_data_o(a_rsp_data),
`ifdef CPU_HOST_POSCAP_EN
      .is_positive_i(1'b0), .rsp_pos_o(a_pos),
`endif
      .dor_o(a_dor), .addr_o(a_addr), .instr_o(a_instr),
      .vout_addr_o(a_vout), .value_i(a_value)
   );

   cpu_host_port #(.HOLD_CYCLES(4), .SETTLE(2), .NBYTES(2)) u_b (
      .clk_i(clk_i), .reset(reset),
      .cmd_valid_i(b_valid), .cmd_ready_o(b_ready), .cmd_op_i(b_op),
      .cmd_sel_i(b_sel), .cmd_addr_i(b_addr_i), .cmd_data_i(b_data_i),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_data_o(b_rsp_data),
`ifdef CPU_HOST_POSCAP_EN
      .is_positive_i(b_is_pos), .rsp_pos_o(b_pos),
`endif
      .dor_o(b_dor), .addr_o(b_addr), .instr_o(b_instr),
      .vout_addr_o(b_vout), .value_i(b_value)
   );

   typedef struct {
      logic [1:0]  op;
      logic        sel;
      logic [4:0]  addr;
      logic [7:0]  data;
      logic [31:0] mem;
      logic        exp_dor;
      logic [4:0]  exp_addr;
      logic [7:0]  exp_instr;
      logic [1:0]  exp_vout;
      int          exp_busy;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic sel, input logic [4:0] addr,
                               input logic [7:0] data, input logic [31:0] mem,
                               input logic edor, input logic [4:0] eaddr, input logic [7:0] einstr,
                               input logic [1:0] evout, input int ebusy, input logic [31:0] edata);
      vec_t v;
      v.op = op; v.sel = sel; v.addr = addr; v.data = data; v.mem = mem;
      v.exp_dor = edor; v.exp_addr = eaddr; v.exp_instr = einstr;
      v.exp_vout = evout; v.exp_busy = ebusy; v.exp_data = edata;
      return v;
   endfunction

   task automatic wait_a_idle(input string name);
      int n = 0;
      while (!a_ready && n < 50) begin
         @(posedge clk_i); #1;
         n++;
      end
      check({name, "_idle"}, {31'd0, a_ready}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int n = 0;
      wait_a_idle(tag);
      @(negedge clk_i);
      a_valid = 1'b1; a_op = v.op; a_sel = v.sel; a_addr_i = v.addr; a_data_i = v.data;
      a_mem = v.mem;
      @(posedge clk_i); #1;
      a_valid = 1'b0;
      check({tag, "_dor"},   {31'd0, a_dor},   {31'd0, v.exp_dor});
      check({tag, "_addr"},  {27'd0, a_addr},  {27'd0, v.exp_addr});
      check({tag, "_instr"}, {24'd0, a_instr}, {24'd0, v.exp_instr});
      if (v.op == 2'b01) begin
         while (!a_rsp_valid && n < 50) begin
            @(posedge clk_i); #1;
            n++;
         end
         check({tag, "_rsp_lat"}, n, v.exp_busy);
         check({tag, "_rsp_data"}, a_rsp_data, v.exp_data);
         @(negedge clk_i);
         a_rsp_ready = 1'b1;
         @(posedge clk_i); #1;
         a_rsp_ready = 1'b0;
         check({tag, "_rsp_drop"}, {31'd0, a_rsp_valid}, 32'd0);
         check({tag, "_ready_after"}, {31'd0, a_ready}, 32'd1);
      end else begin
         while (!a_ready && n < 50) begin
            @(posedge clk_i); #1;
            n++;
         end
         check({tag, "_busy"}, n, v.exp_busy);
      end
      check({tag, "_vout"}, {30'd0, a_vout}, {30'd0, v.exp_vout});
      check({tag, "_data_hold"}, a_rsp_data, v.exp_data);
   endtask

   initial begin
      int n;
      logic saw;

      vecs[0] = mk(2'b00, 1'b1, 5'h0A, 8'hB7, 32'h0,        1'b1, 5'h0A, 8'hB7, 2'd0, 4, 32'h0);
      vecs[1] = mk(2'b01, 1'b0, 5'h03, 8'h00, 32'h44332211, 1'b0, 5'h03, 8'hB7, 2'd3, 8, 32'h44332211);
      vecs[2] = mk(2'b10, 1'b1, 5'h1F, 8'hFF, 32'h0,        1'b0, 5'h03, 8'hB7, 2'd3, 0, 32'h44332211);
      vecs[3] = mk(2'b00, 1'b0, 5'h15, 8'h5A, 32'h0,        1'b0, 5'h15, 8'h5A, 2'd3, 4, 32'h44332211);
      vecs[4] = mk(2'b01, 1'b1, 5'h1F, 8'h00, 32'hD3C2B1A0, 1'b1, 5'h1F, 8'h5A, 2'd3, 8, 32'hD3C2B1A0);
      vecs[5] = mk(2'b11, 1'b1, 5'h01, 8'h77, 32'h0,        1'b1, 5'h1F, 8'h5A, 2'd3, 0, 32'hD3C2B1A0);

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      reset = 1'b0;
      @(posedge clk_i); #1;
      check("rst_ready",     {31'd0, a_ready},     32'd1);
      check("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
      check("rst_rsp_data",  a_rsp_data,           32'd0);
      check("rst_dor",       {31'd0, a_dor},       32'd0);
      check("rst_addr",      {27'd0, a_addr},      32'd0);
      check("rst_instr",     {24'd0, a_instr},     32'd0);
      check("rst_vout",      {30'd0, a_vout},      32'd0);

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      // Response backpressure with a competing command offered.
      wait_a_idle("bp");
      @(negedge clk_i);
      a_valid = 1'b1; a_op = 2'b01; a_sel = 1'b0; a_addr_i = 5'h02; a_mem = 32'h04030201;
      @(posedge clk_i); #1;
      a_valid = 1'b0;
      n = 0;
      while (!a_rsp_valid && n < 50) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("bp_rsp_lat", n, 8);
      @(negedge clk_i);
      a_valid = 1'b1; a_op = 2'b00; a_sel = 1'b0; a_addr_i = 5'h07; a_data_i = 8'hC3;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk_i); #1;
         check($sformatf("bp_valid_c%0d", c), {31'd0, a_rsp_valid}, 32'd1);
         check($sformatf("bp_data_c%0d", c),  a_rsp_data, 32'h04030201);
         check($sformatf("bp_ready_c%0d", c), {31'd0, a_ready}, 32'd0);
      end
      @(negedge clk_i);
      a_rsp_ready = 1'b1;
      @(posedge clk_i); #1;
      a_rsp_ready = 1'b0;
      check("bp_hs_drop",   {31'd0, a_rsp_valid}, 32'd0);
      check("bp_hs_idle",   {31'd0, a_ready},     32'd1);
      check("bp_not_taken", {24'd0, a_instr},     {24'd0, 8'h5A});
      @(posedge clk_i); #1;
      a_valid = 1'b0;
      check("bp_wr_taken", {31'd0, a_ready},  32'd0);
      check("bp_wr_instr", {24'd0, a_instr},  {24'd0, 8'hC3});
      check("bp_wr_addr",  {27'd0, a_addr},   {27'd0, 5'h07});

      // Reset while the read is settling byte 2.
      wait_a_idle("rr");
      @(negedge clk_i);
      a_valid = 1'b1; a_op = 2'b01; a_sel = 1'b1; a_addr_i = 5'h09; a_mem = 32'h55667788;
      @(posedge clk_i); #1;
      a_valid = 1'b0;
      repeat (5) begin
         @(posedge clk_i); #1;
      end
      check("rr_vout_k2", {30'd0, a_vout}, 32'd2);
      @(negedge clk_i);
      reset = 1'b1;
      @(posedge clk_i); #1;
      check("rr_ready", {31'd0, a_ready},     32'd1);
      check("rr_vout",  {30'd0, a_vout},      32'd0);
      check("rr_rsp",   {31'd0, a_rsp_valid}, 32'd0);
      check("rr_dor",   {31'd0, a_dor},       32'd0);
      @(negedge clk_i);
      reset = 1'b0;
      saw = 1'b0;
      repeat (12) begin
         @(posedge clk_i); #1;
         saw = saw | a_rsp_valid;
      end
      check("rr_no_rsp", {31'd0, saw}, 32'd0);
      run_vec(mk(2'b01, 1'b1, 5'h11, 8'h00, 32'h0A0B0C0D,
                 1'b1, 5'h11, 8'h00, 2'd3, 8, 32'h0A0B0C0D), "rr_after");

      // NBYTES = 2 instance: reserved op, then a short read.
      @(negedge clk_i);
      b_valid = 1'b1; b_op = 2'b10; b_sel = 1'b1; b_addr_i = 5'h1F; b_data_i = 8'hFF;
      @(posedge clk_i); #1;
      b_valid = 1'b0;
      check("nb_resv_ready", {31'd0, b_ready}, 32'd1);
      check("nb_resv_dor",   {31'd0, b_dor},   32'd0);
      check("nb_resv_addr",  {27'd0, b_addr},  32'd0);
      check("nb_resv_instr", {24'd0, b_instr}, 32'd0);
      @(negedge clk_i);
      b_valid = 1'b1; b_op = 2'b01; b_sel = 1'b0; b_addr_i = 5'h04; b_mem = 32'hEEFF2211;
      @(posedge clk_i); #1;
      b_valid = 1'b0;
      n = 0;
      while (!b_rsp_valid && n < 50) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("nb_rsp_lat",  n, 4);
      check("nb_rsp_data", b_rsp_data, 32'h00002211);
      check("nb_vout",     {30'd0, b_vout}, 32'd1);
`ifdef CPU_HOST_POSCAP_EN
      check("nb_pos", {31'd0, b_pos}, 32'd1);
      check("a_pos",  {31'd0, a_pos}, 32'd0);
`endif
      @(negedge clk_i);
      b_rsp_ready = 1'b1;
      @(posedge clk_i); #1;
      b_rsp_ready = 1'b0;
      check("nb_rsp_drop", {31'd0, b_rsp_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
